// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the R/I-type + BEQ datapath: fetch handshake with timeout trap,
// per-state datapath enables and mux selects, and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             trap_o,
  output logic             trap_cause_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExecR  = 3'd3;
  localparam logic [2:0] StExecI  = 3'd4;
  localparam logic [2:0] StBranch = 3'd5;
  localparam logic [2:0] StWb     = 3'd6;
  localparam logic [2:0] StTrap   = 3'd7;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  // Counter value seen during the last allowed FETCH cycle.
  localparam logic [7:0] WaitLast = 8'(FETCH_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // A ready arriving on the final allowed cycle still completes the fetch.
        if (imem_ready_i) begin
          wait_d  = 8'd0;
          state_d = StDecode;
        end else if (wait_q >= WaitLast) begin
          cause_d = 1'b1;
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (opcode_i == OpR) begin
          state_d = StExecR;
        end else if (opcode_i == OpI) begin
          state_d = StExecI;
        end else if (opcode_i == OpBeq) begin
          state_d = StBranch;
        end else begin
          cause_d = 1'b0;
          state_d = StTrap;
        end
      end
      StExecR, StExecI: state_d = StWb;
      StWb, StBranch: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      cause_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    imem_req_o  = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    reg_write_o = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 2'd0;
    alu_op_o    = 2'b00;
    trap_o      = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_o  = 1'b1;
          pc_write_o  = 1'b1;
          alu_src_b_o = 2'd2;
        end
      end
      StDecode: alu_src_b_o = 2'd1;
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd1;
        alu_op_o    = 2'b10;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_write_o  = zero_i;
        pc_src_o    = zero_i;
      end
      StWb:   reg_write_o = 1'b1;
      StTrap: trap_o = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;
  assign retired_o    = retired_q;

endmodule
